// File: rtl/serial_parallel_aligner_pkg.sv
// Shared definitions for the comma-aligning serial-to-parallel receiver.
// Holds the FSM state encoding, the default comma symbol and the counter sizing helper.
package serial_parallel_aligner_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_parallel_aligner_sp_shift_window.sv
// Serial shift register exposing a WIDTH-bit window: the current bit plus the previous WIDTH-1 bits.
// The newest bit sits in the LSB so a word sent MSB first lines up with its natural bit order.
module sp_shift_window #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] window
);

    logic [WIDTH-2:0] sr;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sr <= '0;
        end else begin
            sr <= window[WIDTH-2:0];
        end
    end

    assign window = {sr, data_in};

endmodule

// File: rtl/serial_parallel_aligner.sv
// Comma-aligned deserialiser for a PHY receive lane: searches for COMMA at any bit offset,
// locks after LOCK_COUNT aligned commas and drops lock after MISALIGN_LIMIT misaligned ones.
module serial_parallel_aligner
    import serial_parallel_aligner_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] COMMA          = WIDTH'(COMMA_DEFAULT),
    parameter int               LOCK_COUNT     = 4,
    parameter int               MISALIGN_LIMIT = 2
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             active
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int CC_W  = cnt_width(LOCK_COUNT);
    localparam int MC_W  = cnt_width(MISALIGN_LIMIT);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CC_W-1:0]  LOCK_MAX = CC_W'(LOCK_COUNT);
    localparam logic [MC_W-1:0]  MIS_MAX  = MC_W'(MISALIGN_LIMIT);

    logic [WIDTH-1:0] window;

    state_t           state,        state_nxt;
    logic [BIT_W-1:0] bit_cnt,      bit_cnt_nxt;
    logic [CC_W-1:0]  comma_cnt,    comma_cnt_nxt;
    logic [MC_W-1:0]  mis_cnt,      mis_cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt;
    logic             strobe_nxt;
    logic             active_nxt;

    logic             is_comma;
    logic             boundary;
    logic [CC_W-1:0]  comma_cnt_inc;
    logic [MC_W-1:0]  mis_cnt_inc;

    sp_shift_window #(
        .WIDTH (WIDTH)
    ) u_window (
        .clk     (clk_32f),
        .reset_L (reset_L),
        .data_in (data_in),
        .window  (window)
    );

    assign is_comma      = (window == COMMA);
    assign boundary      = (state != SEARCH) && (bit_cnt == LAST_BIT);
    assign comma_cnt_inc = comma_cnt + CC_W'(1);
    assign mis_cnt_inc   = mis_cnt + MC_W'(1);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state       <= SEARCH;
            bit_cnt     <= '0;
            comma_cnt   <= '0;
            mis_cnt     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            comma_cnt   <= comma_cnt_nxt;
            mis_cnt     <= mis_cnt_nxt;
            data_out    <= data_nxt;
            valid_out   <= valid_nxt;
            word_strobe <= strobe_nxt;
            active      <= active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = boundary ? '0 : bit_cnt + BIT_W'(1);
        comma_cnt_nxt = comma_cnt;
        mis_cnt_nxt   = mis_cnt;
        data_nxt      = data_out;
        valid_nxt     = valid_out;
        strobe_nxt    = boundary;
        active_nxt    = active;

        case (state)
            SEARCH: begin
                // Bit position is meaningless until a comma fixes the word phase.
                bit_cnt_nxt = '0;
                if (is_comma) begin
                    comma_cnt_nxt = CC_W'(1);
                    mis_cnt_nxt   = '0;
                    if (LOCK_COUNT == 1) begin
                        state_nxt  = LOCKED;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (comma_cnt_inc >= LOCK_MAX) begin
                            comma_cnt_nxt = LOCK_MAX;
                            mis_cnt_nxt   = '0;
                            state_nxt     = LOCKED;
                            active_nxt    = 1'b1;
                        end else begin
                            comma_cnt_nxt = comma_cnt_inc;
                        end
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = SEARCH;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        valid_nxt   = 1'b0;
                        mis_cnt_nxt = '0;
                    end else begin
                        data_nxt  = window;
                        valid_nxt = 1'b1;
                    end
                end else if (is_comma) begin
                    // A comma off the word grid suggests slipped alignment; tolerate a few.
                    if (mis_cnt_inc >= MIS_MAX) begin
                        mis_cnt_nxt   = MIS_MAX;
                        comma_cnt_nxt = '0;
                        state_nxt     = SEARCH;
                        active_nxt    = 1'b0;
                        valid_nxt     = 1'b0;
                    end else begin
                        mis_cnt_nxt = mis_cnt_inc;
                    end
                end
            end

            default: begin
                state_nxt  = SEARCH;
                active_nxt = 1'b0;
                valid_nxt  = 1'b0;
            end
        endcase
    end

endmodule
